// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, cache rw
// constants and a small round-robin pointer helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Direction encoding used by the caches on their rw line.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Channel index following g, wrapping modulo n.
    function automatic int unsigned ptr_wrap(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requesting channel at
// or after ptr (wrapping) and a flag saying whether any channel requests.
module rr_pick #(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [$clog2(NCH)-1:0] grant,
    output logic                   any
);

    localparam int IW = $clog2(NCH);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin : pick_scan
        int idx;
        idx   = 0;
        grant = ptr;
        any   = 1'b0;
        for (int off = NCH - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NCH;
            if (req[idx]) begin
                grant = IW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter merging cache system ports onto one memory
// port. Optional abort-on-timeout is built only when ARB_TIMEOUT_EN is defined.
//
// Handshake: a channel raises ch_strobe with rw/address/wdata stable and holds
// it until it samples its ch_ready bit high, dropping it on that same edge.
// ch_ready is a one-cycle pulse; ch_rdata (and ch_error) are valid with it.
// The memory side holds mem_enable high until mem_ready is sampled high.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         ch_strobe,
    input  logic [NCH-1:0]         ch_rw,
    input  logic [NCH*AW-1:0]      ch_address,
    input  logic [NCH*DW-1:0]      ch_wdata,
    output logic [DW-1:0]          ch_rdata,
    output logic [NCH-1:0]         ch_ready,
    output logic [NCH-1:0]         ch_error,
    output logic                   mem_enable,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [AW-1:0]          mem_address,
    output logic [DW-1:0]          mem_in,
    input  logic [DW-1:0]          mem_out,
    input  logic                   mem_ready,
    output logic [$clog2(NCH)-1:0] grant_id,
    output logic [1:0]             dbg_state
);

    localparam int IW = $clog2(NCH);

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  rr_ptr_q;
    logic [IW-1:0]  pick_id;
    logic           pick_any;
    logic           sel_rw;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [NCH-1:0] grant_onehot;
    logic           timeout_hit;

    rr_pick #(.NCH(NCH)) u_pick (
        .req   (ch_strobe),
        .ptr   (rr_ptr_q),
        .grant (pick_id),
        .any   (pick_any)
    );

    assign sel_rw       = ch_rw[pick_id];
    assign sel_addr     = ch_address[int'(pick_id)*AW +: AW];
    assign sel_wdata    = ch_wdata[int'(pick_id)*DW +: DW];
    assign grant_onehot = NCH'(1) << grant_id;
    assign dbg_state    = state_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q;

    assign timeout_hit = (tmo_cnt_q == CW'(TIMEOUT - 1));

    // Wait counter: held clear outside BUSY, counts each BUSY cycle without mem_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != BUSY) begin
            tmo_cnt_q <= '0;
        end else if (!mem_ready) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Abort flag pulses alongside ch_ready when the wait expires.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ch_error <= '0;
        end else if (state_q == BUSY && !mem_ready && timeout_hit) begin
            ch_error <= grant_onehot;
        end else begin
            ch_error <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ch_error    = '0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs: latch the winner in IDLE, finish the access in BUSY,
    // advance the round-robin pointer in RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            grant_id    <= '0;
            ch_ready    <= '0;
            ch_rdata    <= '0;
            mem_enable  <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;
        end else begin
            ch_ready <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_id    <= pick_id;
                        mem_enable  <= 1'b1;
                        mem_read    <= (sel_rw == RW_READ);
                        mem_write   <= (sel_rw == RW_WRITE);
                        mem_address <= sel_addr;
                        mem_in      <= sel_wdata;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (mem_read) ch_rdata <= mem_out;
                        ch_ready   <= grant_onehot;
                        mem_enable <= 1'b0;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                    end else if (timeout_hit) begin
                        ch_rdata   <= '0;
                        ch_ready   <= grant_onehot;
                        mem_enable <= 1'b0;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                    end
                end
                RESP: begin
                    rr_ptr_q <= IW'(ptr_wrap(int'(grant_id), NCH));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-channel instance for the main scenarios
// and a 4-channel instance for round-robin fairness.
module tb_mem_arbiter;
    import arb_pkg::*;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    // ---------------- 2-channel DUT ----------------
    logic [1:0]  strobe2 = '0, rw2 = '0, ready2, error2;
    logic [63:0] addr2 = '0, wdata2 = '0;
    logic [31:0] rdata2, maddr2, min2, mout2 = '0;
    logic        en2, rd2, wr2, mready2 = 1'b0;
    logic [0:0]  gid2;
    logic [1:0]  st2;

    mem_arbiter #(.NCH(2), .AW(32), .DW(32), .TIMEOUT(8)) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .ch_strobe(strobe2), .ch_rw(rw2), .ch_address(addr2), .ch_wdata(wdata2),
        .ch_rdata(rdata2), .ch_ready(ready2), .ch_error(error2),
        .mem_enable(en2), .mem_read(rd2), .mem_write(wr2),
        .mem_address(maddr2), .mem_in(min2), .mem_out(mout2), .mem_ready(mready2),
        .grant_id(gid2), .dbg_state(st2)
    );

    // ---------------- 4-channel DUT ----------------
    logic [3:0]   strobe4 = '0, rw4 = '0, ready4, error4;
    logic [127:0] addr4 = '0, wdata4 = '0;
    logic [31:0]  rdata4, maddr4, min4, mout4 = '0;
    logic         en4, rd4, wr4, mready4 = 1'b0;
    logic [1:0]   gid4, st4;

    mem_arbiter #(.NCH(4), .AW(32), .DW(32), .TIMEOUT(8)) u_dut4 (
        .clock(clock), .reset_n(reset_n),
        .ch_strobe(strobe4), .ch_rw(rw4), .ch_address(addr4), .ch_wdata(wdata4),
        .ch_rdata(rdata4), .ch_ready(ready4), .ch_error(error4),
        .mem_enable(en4), .mem_read(rd4), .mem_write(wr4),
        .mem_address(maddr4), .mem_in(min4), .mem_out(mout4), .mem_ready(mready4),
        .grant_id(gid4), .dbg_state(st4)
    );

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        step(2);
        @(negedge clock) reset_n = 1'b1;
        step(1);
    endtask

    // Called just after BUSY entry: wait k cycles, then present mem_ready for one cycle.
    task automatic serve2(input int k, input logic [31:0] data);
        step(k);
        mready2 = 1'b1;
        mout2   = data;
        step(1);
        mready2 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        pulse_reset();
        tests_run++;
        if ({en2, rd2, wr2, ready2, error2, gid2} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 0", {en2, rd2, wr2, ready2, error2, gid2});
        end
        tests_run++;
        if ({maddr2, min2, rdata2} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h required 0", {maddr2, min2, rdata2});
        end
        tests_run++;
        if (st2 !== IDLE || st4 !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d/%0d required 0", st2, st4);
        end
    endtask

    task automatic test_single_read();
        rw2[0] = RW_READ;
        addr2[31:0] = 32'h40;
        strobe2[0] = 1'b1;
        step(1);
        tests_run++;
        if ({en2, rd2, wr2, gid2} !== 4'b1100 || maddr2 !== 32'h40) begin
            tests_failed++;
            $display("FAIL read_issue: en/rd/wr/gid=%b addr=%h required 1100 00000040", {en2, rd2, wr2, gid2}, maddr2);
        end
        step(1);
        tests_run++;
        if (ready2 !== 2'b00 || en2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_wait: ready=%b en=%b required 00 1", ready2, en2);
        end
        serve2(1, 32'hDEADBEEF);
        tests_run++;
        if (ready2 !== 2'b01 || rdata2 !== 32'hDEADBEEF || en2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_resp: ready=%b rdata=%h en=%b required 01 deadbeef 0", ready2, rdata2, en2);
        end
        strobe2[0] = 1'b0;
        step(1);
        tests_run++;
        if (ready2 !== 2'b00 || st2 !== IDLE) begin
            tests_failed++;
            $display("FAIL read_pulse_len: ready=%b state=%0d required 00 0", ready2, st2);
        end
        // Stray mem_ready while idle must be ignored.
        mready2 = 1'b1;
        mout2   = 32'h11111111;
        step(2);
        mready2 = 1'b0;
        tests_run++;
        if (ready2 !== 2'b00 || rdata2 !== 32'hDEADBEEF || en2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_ready: ready=%b rdata=%h en=%b required 00 deadbeef 0", ready2, rdata2, en2);
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        rw2 = 2'b11;
        addr2 = {32'h200, 32'h100};
        strobe2 = 2'b11;
        step(1);
        tests_run++;
        if (gid2 !== 1'b0 || maddr2 !== 32'h100) begin
            tests_failed++;
            $display("FAIL sim_first: gid=%0d addr=%h required 0 00000100", gid2, maddr2);
        end
        serve2(0, 32'hA0A0A0A0);
        tests_run++;
        if (ready2 !== 2'b01 || rdata2 !== 32'hA0A0A0A0) begin
            tests_failed++;
            $display("FAIL sim_first_resp: ready=%b rdata=%h required 01 a0a0a0a0", ready2, rdata2);
        end
        strobe2[0] = 1'b0;
        step(2);
        tests_run++;
        if (gid2 !== 1'b1 || maddr2 !== 32'h200 || en2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL sim_second: gid=%0d addr=%h en=%b required 1 00000200 1", gid2, maddr2, en2);
        end
        serve2(1, 32'hB1B1B1B1);
        tests_run++;
        if (ready2 !== 2'b10 || rdata2 !== 32'hB1B1B1B1) begin
            tests_failed++;
            $display("FAIL sim_second_resp: ready=%b rdata=%h required 10 b1b1b1b1", ready2, rdata2);
        end
        strobe2[1] = 1'b0;
        step(1);
        // A lone ch0 access moves the pointer to ch1, so the next pair runs 1 then 0.
        strobe2[0] = 1'b1;
        step(1);
        serve2(0, 32'hC2C2C2C2);
        strobe2[0] = 1'b0;
        step(1);
        strobe2 = 2'b11;
        step(1);
        tests_run++;
        if (gid2 !== 1'b1 || maddr2 !== 32'h200) begin
            tests_failed++;
            $display("FAIL rep_first: gid=%0d addr=%h required 1 00000200", gid2, maddr2);
        end
        serve2(0, 32'hE4E4E4E4);
        strobe2[1] = 1'b0;
        step(2);
        tests_run++;
        if (gid2 !== 1'b0 || maddr2 !== 32'h100) begin
            tests_failed++;
            $display("FAIL rep_second: gid=%0d addr=%h required 0 00000100", gid2, maddr2);
        end
        serve2(0, 32'hD3D3D3D3);
        tests_run++;
        if (ready2 !== 2'b01 || rdata2 !== 32'hD3D3D3D3) begin
            tests_failed++;
            $display("FAIL rep_second_resp: ready=%b rdata=%h required 01 d3d3d3d3", ready2, rdata2);
        end
        strobe2[0] = 1'b0;
        step(1);
    endtask

    task automatic test_write();
        rw2[1] = RW_WRITE;
        addr2[63:32] = 32'h80;
        wdata2[63:32] = 32'h12345678;
        strobe2[1] = 1'b1;
        step(1);
        tests_run++;
        if ({en2, rd2, wr2, gid2} !== 4'b1011 || min2 !== 32'h12345678 || maddr2 !== 32'h80) begin
            tests_failed++;
            $display("FAIL write_issue: en/rd/wr/gid=%b in=%h addr=%h required 1011 12345678 00000080",
                     {en2, rd2, wr2, gid2}, min2, maddr2);
        end
        serve2(1, 32'hBAD0BAD0);
        tests_run++;
        if (ready2 !== 2'b10 || rdata2 !== 32'hD3D3D3D3 || wr2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_resp: ready=%b rdata=%h wr=%b required 10 d3d3d3d3 0", ready2, rdata2, wr2);
        end
        strobe2[1] = 1'b0;
        step(1);
    endtask

    task automatic test_fairness();
        int guard;
        int g;
        for (int i = 0; i < 4; i++) addr4[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h10;
        rw4 = 4'hF;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        strobe4 = 4'hF;
        for (int t = 0; t < 8; t++) begin
            guard = 0;
            while (en4 !== 1'b1 && guard < 20) begin
                step(1);
                guard++;
            end
            g = int'(exp_q.pop_front());
            tests_run++;
            if (en4 !== 1'b1 || gid4 !== 2'(g) || maddr4 !== 32'h1000 + 32'(g) * 32'h10) begin
                tests_failed++;
                $display("FAIL fair_grant%0d: en=%b gid=%0d addr=%h required 1 %0d %h",
                         t, en4, gid4, maddr4, g, 32'h1000 + 32'(g) * 32'h10);
            end
            mready4 = 1'b1;
            mout4 = 32'(t);
            step(1);
            mready4 = 1'b0;
            tests_run++;
            if (ready4 !== 4'(1 << g)) begin
                tests_failed++;
                $display("FAIL fair_ready%0d: got %b required %b", t, ready4, 4'(1 << g));
            end
            strobe4[g] = 1'b0;
            step(2);
            strobe4[g] = 1'b1;
        end
        strobe4 = '0;
        mready4 = 1'b1;
        step(1);
        mready4 = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid_busy();
        logic saw_ready;
        rw2[0] = RW_READ;
        addr2[31:0] = 32'h300;
        wdata2[31:0] = 32'hFEEDF00D;
        strobe2[0] = 1'b1;
        step(3);
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({en2, rd2, wr2, ready2, error2, gid2} !== 7'd0 || st2 !== IDLE) begin
            tests_failed++;
            $display("FAIL midrst_ctrl: got %b state=%0d required 0 0", {en2, rd2, wr2, ready2, error2, gid2}, st2);
        end
        tests_run++;
        if ({maddr2, min2, rdata2} !== 96'd0) begin
            tests_failed++;
            $display("FAIL midrst_data: got %h required 0", {maddr2, min2, rdata2});
        end
        strobe2 = '0;
        saw_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step(1);
            saw_ready |= |ready2;
        end
        @(negedge clock) reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            saw_ready |= |ready2;
        end
        tests_run++;
        if (saw_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_ready: got %b required 0", saw_ready);
        end
        rw2[1] = RW_READ;
        addr2[63:32] = 32'h400;
        strobe2[1] = 1'b1;
        step(1);
        tests_run++;
        if (gid2 !== 1'b1 || maddr2 !== 32'h400 || en2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_after_issue: gid=%0d addr=%h en=%b required 1 00000400 1", gid2, maddr2, en2);
        end
        serve2(0, 32'h5A5A5A5A);
        tests_run++;
        if (ready2 !== 2'b10 || rdata2 !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL midrst_after_resp: ready=%b rdata=%h required 10 5a5a5a5a", ready2, rdata2);
        end
        strobe2[1] = 1'b0;
        step(1);
    endtask

    task automatic test_timeout();
        logic early;
        int busy_cycles;
        rw2[0] = RW_READ;
        addr2[31:0] = 32'h500;
        strobe2[0] = 1'b1;
        step(1);
`ifdef ARB_TIMEOUT_EN
        early = 1'b0;
        for (int c = 1; c < 8; c++) begin
            step(1);
            early |= |ready2;
        end
        tests_run++;
        if (early !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_early: got %b required 0", early);
        end
        step(1);
        tests_run++;
        if (ready2 !== 2'b01 || error2 !== 2'b01 || rdata2 !== 32'd0 || en2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_abort: ready=%b err=%b rdata=%h en=%b required 01 01 0 0", ready2, error2, rdata2, en2);
        end
        strobe2[0] = 1'b0;
        step(1);
        busy_cycles = 0;
`else
        early = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 120; c++) begin
            step(1);
            if (en2 === 1'b1 && st2 === BUSY) busy_cycles++;
            early |= |ready2 | |error2;
        end
        tests_run++;
        if (busy_cycles !== 120 || early !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_tmo_hold: busy=%0d ready_or_err=%b required 120 0", busy_cycles, early);
        end
        serve2(0, 32'h77777777);
        tests_run++;
        if (ready2 !== 2'b01 || error2 !== 2'b00 || rdata2 !== 32'h77777777) begin
            tests_failed++;
            $display("FAIL no_tmo_resp: ready=%b err=%b rdata=%h required 01 00 77777777", ready2, error2, rdata2);
        end
        strobe2[0] = 1'b0;
        step(1);
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_fairness();
        test_reset_mid_busy();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
